// File: rtl/merge_pkg.sv
// Shared definitions for the D/I request merger: FSM state encoding and
// grant direction codes (the same codes splitter_2 uses).
package merge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic DIRECT_TO_D = 1'b0;
  localparam logic DIRECT_TO_I = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter between the D and I sides (combinational).
// A lone requester always wins; on a tie the side that did not win last time is picked.
module rr_arbiter_2
  import merge_pkg::*;
(
  input  logic d_req,
  input  logic i_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_sel
);

  always_comb begin
    grant_valid = d_req | i_req;
    grant_sel   = DIRECT_TO_D;
    if (d_req && i_req) begin
      grant_sel = ~last_grant;
    end else if (i_req) begin
      grant_sel = DIRECT_TO_I;
    end
  end

endmodule

// File: rtl/merger_2.sv
// Merges the D-side and I-side request paths onto one shared memory port,
// holding the winner for MEM_LAT strobe cycles and returning data/done to it.
module merger_2
  import merge_pkg::*;
#(
  parameter int bit_width  = 8,
  parameter int addr_width = 8,
  parameter int MEM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [addr_width-1:0] d_addr,
  input  logic [bit_width-1:0]  d_wdata,
  output logic [bit_width-1:0]  d_rdata,
  output logic                  d_done,
  input  logic                  i_req,
  input  logic [addr_width-1:0] i_addr,
  output logic [bit_width-1:0]  i_rdata,
  output logic                  i_done,
  output logic [addr_width-1:0] mem_addr,
  output logic [bit_width-1:0]  mem_wdata,
  output logic                  mem_ren_n,
  output logic                  mem_wen_n,
  input  logic [bit_width-1:0]  mem_rdata,
  output logic                  owner
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [addr_width-1:0]   addr_reg, addr_next;
  logic [bit_width-1:0]    wdata_reg, wdata_next;
  logic                    we_reg, we_next;
  logic                    owner_reg, owner_next;
  logic                    last_grant_reg, last_grant_next;
  logic [bit_width-1:0]    d_rdata_reg, d_rdata_next;
  logic [bit_width-1:0]    i_rdata_reg, i_rdata_next;
  logic                    grant_valid;
  logic                    grant_sel;

  rr_arbiter_2 u_arb (
    .d_req       (d_req),
    .i_req       (i_req),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      we_reg         <= 1'b0;
      owner_reg      <= DIRECT_TO_D;
      // Pretend I won last so that D takes the first tie after reset.
      last_grant_reg <= DIRECT_TO_I;
      d_rdata_reg    <= '0;
      i_rdata_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      we_reg         <= we_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      d_rdata_reg    <= d_rdata_next;
      i_rdata_reg    <= i_rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    we_next         = we_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    d_rdata_next    = d_rdata_reg;
    i_rdata_next    = i_rdata_reg;
    unique case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          owner_next      = grant_sel;
          last_grant_next = grant_sel;
          cnt_next        = CNT_W'(MEM_LAT - 1);
          state_next      = ACCESS;
          if (grant_sel == DIRECT_TO_D) begin
            addr_next  = d_addr;
            wdata_next = d_wdata;
            we_next    = d_we;
          end else begin
            addr_next  = i_addr;
            wdata_next = '0;
            we_next    = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_reg == '0) begin
          // Last strobe cycle: read data is sampled while ren_n is still low.
          if (!we_reg) begin
            if (owner_reg == DIRECT_TO_D) begin
              d_rdata_next = mem_rdata;
            end else begin
              i_rdata_next = mem_rdata;
            end
          end
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_ren_n = !((state_reg == ACCESS) && !we_reg);
  assign mem_wen_n = !((state_reg == ACCESS) && we_reg);
  assign d_done    = (state_reg == DONE) && (owner_reg == DIRECT_TO_D);
  assign i_done    = (state_reg == DONE) && (owner_reg == DIRECT_TO_I);
  assign d_rdata   = d_rdata_reg;
  assign i_rdata   = i_rdata_reg;
  assign owner     = owner_reg;

endmodule

// File: tb/tb_merger_2.sv
// Directed testbench for merger_2 with MEM_LAT=2; outputs are sampled on the
// falling edge, inputs are driven right after it.
module tb_merger_2;

  logic       clk;
  logic       rst_n;
  logic       d_req, d_we, i_req;
  logic [7:0] d_addr, d_wdata, i_addr, mem_rdata;
  logic [7:0] d_rdata, i_rdata, mem_addr, mem_wdata;
  logic       d_done, i_done, mem_ren_n, mem_wen_n, owner;

  int checks = 0;
  int errors = 0;

  merger_2 #(.bit_width(8), .addr_width(8), .MEM_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ren_n (mem_ren_n),
    .mem_wen_n (mem_wen_n),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ren"},   32'(mem_ren_n), 32'h1);
    chk({tag, "_wen"},   32'(mem_wen_n), 32'h1);
    chk({tag, "_addr"},  32'(mem_addr),  32'h0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, "_drd"},   32'(d_rdata),   32'h0);
    chk({tag, "_ird"},   32'(i_rdata),   32'h0);
    chk({tag, "_done"},  32'({d_done, i_done}), 32'h0);
    chk({tag, "_owner"}, 32'(owner),     32'h0);
  endtask

  initial begin
    rst_n = 1'b0; d_req = 0; d_we = 0; i_req = 0;
    d_addr = 0; d_wdata = 0; i_addr = 0; mem_rdata = 0;
    step(); step();
    chk_reset_outputs("rst");
    $display("reset state checked");
    rst_n = 1'b1;
    step();

    // D read: addr 10, memory returns A5
    d_req = 1; d_we = 0; d_addr = 8'h10; mem_rdata = 8'hA5;
    step();
    chk("drd_acc1_ren", 32'(mem_ren_n), 0);
    chk("drd_acc1_addr", 32'(mem_addr), 32'h10);
    chk("drd_acc1_owner", 32'(owner), 0);
    chk("drd_acc1_done", 32'(d_done), 0);
    step();
    chk("drd_acc2_ren", 32'(mem_ren_n), 0);
    chk("drd_acc2_wen", 32'(mem_wen_n), 1);
    step();
    chk("drd_done", 32'(d_done), 1);
    chk("drd_idone", 32'(i_done), 0);
    chk("drd_rdata", 32'(d_rdata), 32'hA5);
    chk("drd_ren_up", 32'(mem_ren_n), 1);
    d_req = 0;
    step();
    chk("drd_done_pulse", 32'(d_done), 0);
    chk("drd_idle_ren", 32'(mem_ren_n), 1);
    $display("D read: d_rdata=%h", d_rdata);

    // D write: addr 20, data 3C
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 8'h3C; mem_rdata = 8'hEE;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("dwr_wen", 32'(mem_wen_n), 0);
      chk("dwr_ren", 32'(mem_ren_n), 1);
      chk("dwr_addr", 32'(mem_addr), 32'h20);
      chk("dwr_wdata", 32'(mem_wdata), 32'h3C);
    end
    step();
    chk("dwr_done", 32'(d_done), 1);
    chk("dwr_wen_up", 32'(mem_wen_n), 1);
    chk("dwr_rdata_kept", 32'(d_rdata), 32'hA5);
    d_req = 0; d_we = 0;
    step();
    $display("D write: addr=20 data=3C");

    // Both requesting after reset: alternating D, I, D, I
    rst_n = 0; step(); rst_n = 1; step();
    d_req = 1; i_req = 1; d_addr = 8'h30; i_addr = 8'h31; mem_rdata = 8'h11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_owner", 32'(owner), 32'(k % 2));
      chk("rr_addr", 32'(mem_addr), (k % 2 == 0) ? 32'h30 : 32'h31);
      step();
      step();
      chk("rr_ddone", 32'(d_done), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_idone", 32'(i_done), (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k == 3) begin
        d_req = 0; i_req = 0;
      end
      step();
      $display("RR grant %0d: owner=%0d", k, owner);
    end
    chk("rr_drd", 32'(d_rdata), 32'h11);
    chk("rr_ird", 32'(i_rdata), 32'h11);

    // I read with d_rdata already 11
    i_req = 1; i_addr = 8'h04; mem_rdata = 8'h7E;
    step();
    chk("ird_owner", 32'(owner), 1);
    chk("ird_addr", 32'(mem_addr), 32'h04);
    chk("ird_ren", 32'(mem_ren_n), 0);
    step();
    step();
    chk("ird_done", 32'(i_done), 1);
    chk("ird_ddone", 32'(d_done), 0);
    chk("ird_rdata", 32'(i_rdata), 32'h7E);
    chk("ird_drd_kept", 32'(d_rdata), 32'h11);
    i_req = 0;
    step();
    $display("I read: i_rdata=%h", i_rdata);

    // Reset in the second ACCESS cycle
    d_req = 1; d_we = 0; d_addr = 8'h55; mem_rdata = 8'h99;
    step();
    step();
    chk("mid_ren_low", 32'(mem_ren_n), 0);
    #2 rst_n = 0; d_req = 0;
    #1;
    chk_reset_outputs("midrst");
    step();
    chk("midrst_nodone", 32'({d_done, i_done}), 0);
    step();
    chk("midrst_nodone2", 32'({d_done, i_done}), 0);
    rst_n = 1;
    step();
    chk("post_rst_idle", 32'(mem_ren_n), 1);
    i_req = 1; i_addr = 8'h08; mem_rdata = 8'h42;
    step();
    chk("post_owner", 32'(owner), 1);
    step();
    step();
    chk("post_idone", 32'(i_done), 1);
    chk("post_ird", 32'(i_rdata), 32'h42);
    chk("post_drd", 32'(d_rdata), 32'h0);
    i_req = 0;
    step();
    $display("Post-reset I read: i_rdata=%h", i_rdata);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
